// File: rtl/cache_def.sv
// ---------------------------------------------------------------------------
// cache_def
// Shared types for the cache subsystem's memory interface.
//   mem_req_type  : {addr, data[127:0], rw, valid}, rw = 1 means write
//   mem_data_type : {data[127:0], ready}
//   line_addr()   : clears the byte-in-line offset bits of an address
// ---------------------------------------------------------------------------
package cache_def;

    localparam int LINE_OFFSET_BITS = 4;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return a & ~32'((1 << LINE_OFFSET_BITS) - 1);
    endfunction

endpackage

// File: rtl/mm_watchdog.sv
// ---------------------------------------------------------------------------
// mm_watchdog
// Response watchdog for cache_mem_master. Counts cycles spent waiting for
// 'ready' and flags expiry when the wait reaches TIMEOUT_CYCLES.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : high while a request is outstanding (a WAIT state)
//   ready_i       : responder acknowledge
//   expired_o     : combinational, high in the cycle whose edge completes
//                   TIMEOUT_CYCLES waiting cycles without 'ready'
// TIMEOUT_CYCLES = 0 disables the watchdog.
// ---------------------------------------------------------------------------
module mm_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic ready_i,
    output logic expired_o
);

    logic [15:0] count_q;
    logic [16:0] count_next;

    // Counter is held at zero outside WAIT states, so every WAIT entry
    // starts a fresh count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (!en_i) begin
            count_q <= '0;
        end else if (!ready_i) begin
            count_q <= count_q + 16'd1;
        end
    end

    // Compare the value the counter is about to take, so the error lands on
    // the edge that ends the last allowed waiting cycle.
    assign count_next = {1'b0, count_q} + 17'd1;
    assign expired_o  = en_i && !ready_i && (TIMEOUT_CYCLES != 0)
                        && (count_next == 17'(TIMEOUT_CYCLES));

endmodule

// File: rtl/cache_mem_master.sv
// ---------------------------------------------------------------------------
// cache_mem_master
// Memory-side initiator of the cache: turns a miss (with optional dirty
// victim writeback) into mem_req_type transactions, collects the returned
// line and hands it back as a one-cycle fill. A watchdog aborts requests the
// responder never acknowledges.
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   miss_req_i        : miss request, accepted while miss_ready_o is high
//   miss_addr_i       : byte address of the missing line
//   dirty_i           : victim must be written back first
//   victim_addr_i/data: victim line address and contents
//   miss_ready_o      : idle, able to accept a miss
//   fill_valid_o      : one-cycle fill strobe
//   fill_addr_o/data_o: filled line address and data (held between fills)
//   mem_request_o     : registered request toward memory
//   mem_result_i      : memory response {data, ready}
//   err_o             : sticky watchdog timeout flag
//   err_clr_i         : clears err_o and leaves ERROR
// ---------------------------------------------------------------------------
module cache_mem_master
    import cache_def::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         miss_req_i,
    input  logic [31:0]  miss_addr_i,
    input  logic         dirty_i,
    input  logic [31:0]  victim_addr_i,
    input  logic [127:0] victim_data_i,
    output logic         miss_ready_o,
    output logic         fill_valid_o,
    output logic [31:0]  fill_addr_o,
    output logic [127:0] fill_data_o,
    output mem_req_type  mem_request_o,
    input  mem_data_type mem_result_i,
    output logic         err_o,
    input  logic         err_clr_i
);

    typedef enum logic [2:0] {
        IDLE,
        WB_WAIT,
        RD_ISSUE,
        RD_WAIT,
        FILL,
        ERROR
    } state_e;

    state_e       state_q, state_d;
    mem_req_type  req_q, req_d;
    logic [31:0]  miss_addr_q, miss_addr_d;
    logic [31:0]  fill_addr_q, fill_addr_d;
    logic [127:0] fill_data_q, fill_data_d;
    logic         err_q, err_d;
    logic         in_wait;
    logic         expired;

    assign in_wait = (state_q == WB_WAIT) || (state_q == RD_WAIT);

    mm_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en_i     (in_wait),
        .ready_i  (mem_result_i.ready),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request, captured miss address, fill registers and error flag. Reset
    // clears the request immediately so an aborted transaction never
    // completes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q       <= '0;
            miss_addr_q <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            req_q       <= req_d;
            miss_addr_q <= miss_addr_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            err_q       <= err_d;
        end
    end

    // 'ready' is only looked at in the WAIT states; stray acks elsewhere
    // (e.g. while memory boots) fall through untouched. A timeout can only
    // occur in a WAIT state, so it always takes precedence over err_clr_i.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        miss_addr_d = miss_addr_q;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (miss_req_i) begin
                    miss_addr_d = line_addr(miss_addr_i);
                    req_d.valid = 1'b1;
                    if (dirty_i) begin
                        req_d.addr = line_addr(victim_addr_i);
                        req_d.data = victim_data_i;
                        req_d.rw   = 1'b1;
                        state_d    = WB_WAIT;
                    end else begin
                        req_d.addr = line_addr(miss_addr_i);
                        req_d.data = '0;
                        req_d.rw   = 1'b0;
                        state_d    = RD_WAIT;
                    end
                end
            end
            WB_WAIT: begin
                if (expired) begin
                    req_d.valid = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ERROR;
                end else if (mem_result_i.ready) begin
                    req_d.valid = 1'b0;
                    state_d     = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                req_d.addr  = miss_addr_q;
                req_d.data  = '0;
                req_d.rw    = 1'b0;
                req_d.valid = 1'b1;
                state_d     = RD_WAIT;
            end
            RD_WAIT: begin
                if (expired) begin
                    req_d.valid = 1'b0;
                    err_d       = 1'b1;
                    state_d     = ERROR;
                end else if (mem_result_i.ready) begin
                    fill_data_d = mem_result_i.data;
                    fill_addr_d = miss_addr_q;
                    req_d.valid = 1'b0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            ERROR: begin
                if (err_clr_i) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign miss_ready_o  = (state_q == IDLE);
    assign fill_valid_o  = (state_q == FILL);
    assign fill_addr_o   = fill_addr_q;
    assign fill_data_o   = fill_data_q;
    assign mem_request_o = req_q;
    assign err_o         = err_q;

endmodule

// File: doc/cache_mem_master.md
# cache_mem_master

Memory-side initiator of the cache subsystem: turns a cache miss, with an optional dirty-victim writeback, into a sequence of `mem_req_type` transactions toward the memory/SRAM responder. It collects the 128-bit line from `mem_data_type` and returns it to the cache as a single-cycle fill. It sits between the cache controller FSM and the memory block, owns all request sequencing, and enforces a response watchdog.

## Interface
- `TIMEOUT_CYCLES`, default 65535: maximum cycles a request may wait for `ready`; 0 disables the watchdog.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `miss_req_i`  in  1  cache requests a line fill.
- `miss_addr_i`  in  32  byte address of the missing line.
- `dirty_i`  in  1  the victim line must be written back first.
- `victim_addr_i`  in  32  byte address of the victim line.
- `victim_data_i`  in  128  victim line data.
- `miss_ready_o`  out  1  block idle; a miss can be accepted.
- `fill_valid_o`  out  1  one-cycle strobe: fill data is valid.
- `fill_addr_o`  out  32  line address of the fill (bits [3:0] = 0).
- `fill_data_o`  out  128  filled line.
- `mem_request_o`  out  mem_req_type  `{addr, data[127:0], rw, valid}`; `rw` = 1 means write.
- `mem_result_i`  in  mem_data_type  `{data[127:0], ready}`.
- `err_o`  out  1  sticky watchdog timeout flag.
- `err_clr_i`  in  1  clears `err_o` and leaves the ERROR state.

## Operation
- States: IDLE, WB_WAIT, RD_ISSUE, RD_WAIT, FILL, ERROR. `miss_ready_o` = (state == IDLE).
- **IDLE**
  - Accepts when `miss_req_i` & `miss_ready_o` are both high. All inputs are captured into registers at that edge.
  - If `dirty_i` = 1: load the writeback request (`addr` = victim_addr & ~0xF, `data` = victim_data, `rw` = 1, `valid` = 1) and go to WB_WAIT.
  - Else: load the read request (`addr` = miss_addr & ~0xF, `rw` = 0, `valid` = 1, `data` = 0) and go to RD_WAIT.
- **WB_WAIT**
  - Holds the request stable.
  - On `ready`: clear `valid` and go to RD_ISSUE.
- **RD_ISSUE**
  - `valid` is low for exactly one cycle.
  - Load the read request and go to RD_WAIT.
- **RD_WAIT**
  - Holds the request stable.
  - On `ready`: latch `mem_result_i.data` into `fill_data_o`, clear `valid`, and go to FILL.
- **FILL**
  - `fill_valid_o` = 1 for one cycle, then go to IDLE.
- **Watchdog**
  - A 16-bit counter, cleared on entry to any WAIT state, increments each WAIT cycle without `ready`.
  - When the count reaches `TIMEOUT_CYCLES` (≠ 0): clear `valid`, set `err_o`, go to ERROR.
- **ERROR**
  - No requests are issued and `miss_ready_o` = 0.
  - `err_clr_i` clears `err_o` and the block goes to IDLE.
  - The aborted miss is dropped; the cache must re-issue it.
- `ready` is ignored in IDLE, RD_ISSUE, FILL and ERROR. This covers stray acks while the memory block is still booting.
- `fill_addr_o` and `fill_data_o` hold their last values outside FILL.

## Timing
- Reset: all outputs 0 except `miss_ready_o` = 1. State goes to IDLE and the counter to 0. An asynchronous reset mid-transaction drops `valid` immediately, with no completion.
- Clean miss:
  - Accept at edge k; `valid` is high from cycle k+1.
  - If `ready` is sampled at edge m, then `fill_valid_o` is high in cycle m+1 and `miss_ready_o` is high again in cycle m+2.
  - Minimum latency is accept → fill strobe = 2 cycles, when `ready` arrives in the first valid cycle.
- Dirty miss: `valid` drops for one cycle between the write and the read. Minimum is 4 cycles from accept to fill strobe.
- `ready` coincident with the first cycle of `valid` completes the transaction.
- The request fields are registered and never change while `valid` = 1.
- Timeout: `valid` has been high for `TIMEOUT_CYCLES` cycles without `ready` → `err_o` is set at the next edge.
- `err_clr_i` asserted in the same cycle as the timeout: the timeout wins and `err_o` is set.

## Structure
- Package `cache_def` holds `mem_req_type`, `mem_data_type` and the constant `LINE_OFFSET_BITS` = 4.
- The state enum is local to the block.
- One natural sub-module: `mm_watchdog`, which holds the counter, the compare against `TIMEOUT_CYCLES`, and the clear/enable logic.

## Test plan
- **Clean miss:** `miss_addr_i` = 0x0000_0824, responder acks 3 cycles after `valid` with data 0x…DEADBEEF → request shows `addr` = 0x820, `rw` = 0; `fill_valid_o` is a single-cycle strobe with `fill_addr_o` = 0x820 and that data.
- **Dirty miss:** victim 0x400 with data pattern A, miss 0x810, both acks immediate → write to 0x400 with A, one cycle with `valid` = 0, read of 0x810, fill strobe 4 cycles after accept.
- **Stray ack:** `ready` pulses while in IDLE and during RD_ISSUE → ignored; no state change and no fill.
- **Timeout:** `TIMEOUT_CYCLES` = 16, responder silent → `err_o` = 1 after 16 valid cycles, `valid` = 0 and `miss_ready_o` = 0. Pulse `err_clr_i` → IDLE, then a new miss completes normally.
- **Reset mid-read:** deassert `rst_ni` in RD_WAIT → `valid` = 0 immediately and `miss_ready_o` = 1 after reset release.
- **Back-to-back:** a second miss is held high through the first → it is accepted in the cycle `miss_ready_o` returns, with no lost or duplicated transaction.
